// File: rtl/decode_pipe.sv
// RV32I decode stage: a DEPTH-entry instruction queue feeding a combinational
// decoder whose results are captured in a single registered output slot.

`ifndef DECODE_PIPE_ENCODINGS
`define DECODE_PIPE_ENCODINGS
`define ALU_OP_WIDTH     4
`define ALU_OP_NONE      4'd0
`define ALU_OP_ADD       4'd1
`define ALU_OP_SUB       4'd2
`define ALU_OP_SLL       4'd3
`define ALU_OP_SLT       4'd4
`define ALU_OP_SLTU      4'd5
`define ALU_OP_XOR       4'd6
`define ALU_OP_SRL       4'd7
`define ALU_OP_SRA       4'd8
`define ALU_OP_OR        4'd9
`define ALU_OP_AND       4'd10
`define SEL_SRC_A_WIDTH  2
`define SEL_SRC_A_RS1    2'd0
`define SEL_SRC_A_PC     2'd1
`define SEL_SRC_A_ZERO   2'd2
`define SEL_SRC_B_WIDTH  2
`define SEL_SRC_B_RS2    2'd0
`define SEL_SRC_B_IMM    2'd1
`define SEL_SRC_B_FOUR   2'd2
`define SEL_PC_WIDTH     3
`define SEL_PC_ADD4      3'd0
`define SEL_PC_JAL       3'd1
`define SEL_PC_JALR      3'd2
`define SEL_PC_MTVEC     3'd3
`define SEL_PC_MEPC      3'd4
`endif

module decode_pipe #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_pc,
  input  logic [31:0]                 in_code,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4:0]                  rs1_num,
  output logic [4:0]                  rs2_num,
  output logic [4:0]                  rd_num,
  output logic [31:0]                 imm,
  output logic [`ALU_OP_WIDTH-1:0]    alu_op_sel,
  output logic [`SEL_SRC_A_WIDTH-1:0] src_a_sel,
  output logic [`SEL_SRC_B_WIDTH-1:0] src_b_sel,
  output logic [`SEL_PC_WIDTH-1:0]    pc_sel,
  output logic                        wb_reg,
  output logic                        illegal,
  output logic [31:0]                 out_pc
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSN_MRET  = 32'h3020_0073;

  logic [31:0]      pcMem   [DEPTH];
  logic [31:0]      codeMem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, empty;

  logic                        outValid_q;
  logic [4:0]                  rs1_q, rs2_q, rd_q;
  logic [31:0]                 imm_q, pc_q;
  logic [`ALU_OP_WIDTH-1:0]    alu_q;
  logic [`SEL_SRC_A_WIDTH-1:0] srcA_q;
  logic [`SEL_SRC_B_WIDTH-1:0] srcB_q;
  logic [`SEL_PC_WIDTH-1:0]    pcSel_q;
  logic                        wb_q, ill_q;

  logic [31:0] headPc, headCode;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immU, immJ;

  logic [4:0]                  decRs1, decRs2, decRd;
  logic [31:0]                 decImm;
  logic [`ALU_OP_WIDTH-1:0]    decAlu, baseAlu;
  logic [`SEL_SRC_A_WIDTH-1:0] decSrcA;
  logic [`SEL_SRC_B_WIDTH-1:0] decSrcB;
  logic [`SEL_PC_WIDTH-1:0]    decPc;
  logic                        decWb, decIll;

  // A full queue refuses input even if the head leaves this cycle.
  assign empty    = (count_q == '0);
  assign in_ready = rst_n && !flush && (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!outValid_q || out_ready);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr_q]   <= in_pc;
      codeMem[wrPtr_q] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign headPc   = pcMem[rdPtr_q];
  assign headCode = codeMem[rdPtr_q];
  assign opcode   = headCode[6:0];
  assign funct3   = headCode[14:12];
  assign funct7   = headCode[31:25];

  assign immI = {{20{headCode[31]}}, headCode[31:20]};
  assign immS = {{20{headCode[31]}}, headCode[31:25], headCode[11:7]};
  assign immB = {{19{headCode[31]}}, headCode[31], headCode[7], headCode[30:25], headCode[11:8], 1'b0};
  assign immU = {headCode[31:12], 12'b0};
  assign immJ = {{11{headCode[31]}}, headCode[31], headCode[19:12], headCode[20], headCode[30:21], 1'b0};

  always_comb begin
    baseAlu = `ALU_OP_ADD;
    case (funct3)
      3'b000:  baseAlu = `ALU_OP_ADD;
      3'b001:  baseAlu = `ALU_OP_SLL;
      3'b010:  baseAlu = `ALU_OP_SLT;
      3'b011:  baseAlu = `ALU_OP_SLTU;
      3'b100:  baseAlu = `ALU_OP_XOR;
      3'b101:  baseAlu = `ALU_OP_SRL;
      3'b110:  baseAlu = `ALU_OP_OR;
      default: baseAlu = `ALU_OP_AND;
    endcase
  end

  always_comb begin
    decRs1  = headCode[19:15];
    decRs2  = headCode[24:20];
    decRd   = headCode[11:7];
    decImm  = '0;
    decAlu  = `ALU_OP_NONE;
    decSrcA = `SEL_SRC_A_RS1;
    decSrcB = `SEL_SRC_B_RS2;
    decWb   = 1'b0;
    decIll  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        decRs1  = '0;
        decRs2  = '0;
        decImm  = immU;
        decAlu  = `ALU_OP_ADD;
        decSrcA = (opcode == OPC_LUI) ? `SEL_SRC_A_ZERO : `SEL_SRC_A_PC;
        decSrcB = `SEL_SRC_B_IMM;
        decWb   = 1'b1;
      end
      OPC_JAL: begin
        decRs1  = '0;
        decRs2  = '0;
        decImm  = immJ;
        decAlu  = `ALU_OP_ADD;
        decSrcA = `SEL_SRC_A_PC;
        decSrcB = `SEL_SRC_B_FOUR;
        decWb   = 1'b1;
      end
      OPC_JALR: begin
        decRs2  = '0;
        decImm  = immI;
        decAlu  = `ALU_OP_ADD;
        decSrcA = `SEL_SRC_A_PC;
        decSrcB = `SEL_SRC_B_FOUR;
        decWb   = 1'b1;
      end
      OPC_BRANCH: begin
        decRd  = '0;
        decImm = immB;
        case (funct3)
          3'b000, 3'b001: decAlu = `ALU_OP_SUB;
          3'b100, 3'b101: decAlu = `ALU_OP_SLT;
          3'b110, 3'b111: decAlu = `ALU_OP_SLTU;
          default:        decIll = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        decRs2  = '0;
        decImm  = immI;
        decAlu  = `ALU_OP_ADD;
        decSrcB = `SEL_SRC_B_IMM;
        decWb   = 1'b1;
      end
      OPC_STORE: begin
        decRd   = '0;
        decImm  = immS;
        decAlu  = `ALU_OP_ADD;
        decSrcB = `SEL_SRC_B_IMM;
      end
      OPC_OPIMM: begin
        decRs2  = '0;
        decImm  = immI;
        decAlu  = baseAlu;
        decSrcB = `SEL_SRC_B_IMM;
        decWb   = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) decIll = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)      decAlu = `ALU_OP_SRA;
          else if (funct7 != 7'b0000000) decIll = 1'b1;
        end
      end
      OPC_OP: begin
        decWb = 1'b1;
        if (funct7 == 7'b0000000)                         decAlu = baseAlu;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) decAlu = `ALU_OP_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) decAlu = `ALU_OP_SRA;
        else                                              decIll = 1'b1;
      end
      OPC_SYSTEM: begin
        decRs2  = '0;
        decImm  = immI;
        decSrcB = `SEL_SRC_B_IMM;
      end
      default: decIll = 1'b1;
    endcase
    // Illegal encodings present a fully neutral bundle apart from the trap redirect.
    if (decIll) begin
      decRs1  = '0;
      decRs2  = '0;
      decRd   = '0;
      decImm  = '0;
      decAlu  = `ALU_OP_NONE;
      decSrcA = `SEL_SRC_A_RS1;
      decSrcB = `SEL_SRC_B_RS2;
      decWb   = 1'b0;
    end
  end

  always_comb begin
    decPc = `SEL_PC_ADD4;
    if (decIll) begin
      decPc = `SEL_PC_MTVEC;
    end else begin
      case (opcode)
        OPC_JAL:    decPc = `SEL_PC_JAL;
        OPC_JALR:   decPc = `SEL_PC_JALR;
        OPC_SYSTEM: begin
          if (headCode == INSN_ECALL)     decPc = `SEL_PC_MTVEC;
          else if (headCode == INSN_MRET) decPc = `SEL_PC_MEPC;
          else                            decPc = `SEL_PC_ADD4;
        end
        default:    decPc = `SEL_PC_ADD4;
      endcase
    end
  end

  // Fields are only rewritten on a load, so a stalled output stays frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_q      <= '0;
      srcA_q     <= '0;
      srcB_q     <= '0;
      pcSel_q    <= '0;
      wb_q       <= 1'b0;
      ill_q      <= 1'b0;
      pc_q       <= '0;
    end else if (flush) begin
      outValid_q <= 1'b0;
    end else if (pop) begin
      outValid_q <= 1'b1;
      rs1_q      <= decRs1;
      rs2_q      <= decRs2;
      rd_q       <= decRd;
      imm_q      <= decImm;
      alu_q      <= decAlu;
      srcA_q     <= decSrcA;
      srcB_q     <= decSrcB;
      pcSel_q    <= decPc;
      wb_q       <= decWb;
      ill_q      <= decIll;
      pc_q       <= headPc;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid  = outValid_q;
  assign rs1_num    = rs1_q;
  assign rs2_num    = rs2_q;
  assign rd_num     = rd_q;
  assign imm        = imm_q;
  assign alu_op_sel = alu_q;
  assign src_a_sel  = srcA_q;
  assign src_b_sel  = srcB_q;
  assign pc_sel     = pcSel_q;
  assign wb_reg     = wb_q;
  assign illegal    = ill_q;
  assign out_pc     = pc_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus randomized traffic checked
// against a queue-based reference model and an RV32I field decoder.

`ifndef DECODE_PIPE_ENCODINGS
`define DECODE_PIPE_ENCODINGS
`define ALU_OP_WIDTH     4
`define ALU_OP_NONE      4'd0
`define ALU_OP_ADD       4'd1
`define ALU_OP_SUB       4'd2
`define ALU_OP_SLL       4'd3
`define ALU_OP_SLT       4'd4
`define ALU_OP_SLTU      4'd5
`define ALU_OP_XOR       4'd6
`define ALU_OP_SRL       4'd7
`define ALU_OP_SRA       4'd8
`define ALU_OP_OR        4'd9
`define ALU_OP_AND       4'd10
`define SEL_SRC_A_WIDTH  2
`define SEL_SRC_A_RS1    2'd0
`define SEL_SRC_A_PC     2'd1
`define SEL_SRC_A_ZERO   2'd2
`define SEL_SRC_B_WIDTH  2
`define SEL_SRC_B_RS2    2'd0
`define SEL_SRC_B_IMM    2'd1
`define SEL_SRC_B_FOUR   2'd2
`define SEL_PC_WIDTH     3
`define SEL_PC_ADD4      3'd0
`define SEL_PC_JAL       3'd1
`define SEL_PC_JALR      3'd2
`define SEL_PC_MTVEC     3'd3
`define SEL_PC_MEPC      3'd4
`endif

module tb_decode_pipe;
  localparam int DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]                 in_pc, in_code, imm, out_pc;
  logic [4:0]                  rs1_num, rs2_num, rd_num;
  logic [`ALU_OP_WIDTH-1:0]    alu_op_sel;
  logic [`SEL_SRC_A_WIDTH-1:0] src_a_sel;
  logic [`SEL_SRC_B_WIDTH-1:0] src_b_sel;
  logic [`SEL_PC_WIDTH-1:0]    pc_sel;
  logic                        wb_reg, illegal;

  decode_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num), .imm(imm),
    .alu_op_sel(alu_op_sel), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .pc_sel(pc_sel),
    .wb_reg(wb_reg), .illegal(illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
  } entry_t;

  typedef struct packed {
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic [4:0]                  rd;
    logic [31:0]                 imm;
    logic [`ALU_OP_WIDTH-1:0]    alu;
    logic [`SEL_SRC_A_WIDTH-1:0] srcA;
    logic [`SEL_SRC_B_WIDTH-1:0] srcB;
    logic [`SEL_PC_WIDTH-1:0]    pcSel;
    logic                        wb;
    logic                        ill;
    logic [31:0]                 pc;
  } fields_t;

  entry_t  mQueue[$];
  fields_t mOut;
  logic    mValid = 1'b0;
  logic    mZero  = 1'b0;
  logic    mKnown = 1'b0;
  int      checks = 0;
  int      errors = 0;
  int      accCount = 0;
  int      outCount = 0;

  function automatic logic [`ALU_OP_WIDTH-1:0] f3ToAlu(input logic [2:0] f3);
    case (f3)
      3'd0: return `ALU_OP_ADD;
      3'd1: return `ALU_OP_SLL;
      3'd2: return `ALU_OP_SLT;
      3'd3: return `ALU_OP_SLTU;
      3'd4: return `ALU_OP_XOR;
      3'd5: return `ALU_OP_SRL;
      3'd6: return `ALU_OP_OR;
      default: return `ALU_OP_AND;
    endcase
  endfunction

  // Reference decoder: classify the format, then derive fields arithmetically.
  function automatic fields_t refDecode(input logic [31:0] pc, input logic [31:0] code);
    fields_t    f;
    byte        fmt;
    logic       legal;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int         v;
    f = '0;
    op = code[6:0];
    f3 = code[14:12];
    f7 = code[31:25];
    legal = 1'b1;
    fmt = "X";
    f.alu = `ALU_OP_NONE;
    f.srcA = `SEL_SRC_A_RS1;
    f.srcB = `SEL_SRC_B_RS2;
    f.pcSel = `SEL_PC_ADD4;
    case (op)
      7'h37: begin fmt = "U"; f.alu = `ALU_OP_ADD; f.srcA = `SEL_SRC_A_ZERO; f.srcB = `SEL_SRC_B_IMM; f.wb = 1; end
      7'h17: begin fmt = "U"; f.alu = `ALU_OP_ADD; f.srcA = `SEL_SRC_A_PC; f.srcB = `SEL_SRC_B_IMM; f.wb = 1; end
      7'h6F: begin fmt = "J"; f.alu = `ALU_OP_ADD; f.srcA = `SEL_SRC_A_PC; f.srcB = `SEL_SRC_B_FOUR; f.pcSel = `SEL_PC_JAL; f.wb = 1; end
      7'h67: begin fmt = "I"; f.alu = `ALU_OP_ADD; f.srcA = `SEL_SRC_A_PC; f.srcB = `SEL_SRC_B_FOUR; f.pcSel = `SEL_PC_JALR; f.wb = 1; end
      7'h63: begin
        fmt = "B";
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        f.alu = (f3 < 3'd2) ? `ALU_OP_SUB : (f3 < 3'd6) ? `ALU_OP_SLT : `ALU_OP_SLTU;
      end
      7'h03: begin fmt = "I"; f.alu = `ALU_OP_ADD; f.srcB = `SEL_SRC_B_IMM; f.wb = 1; end
      7'h23: begin fmt = "S"; f.alu = `ALU_OP_ADD; f.srcB = `SEL_SRC_B_IMM; end
      7'h13: begin
        fmt = "I"; f.alu = f3ToAlu(f3); f.srcB = `SEL_SRC_B_IMM; f.wb = 1;
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) f.alu = `ALU_OP_SRA;
          else legal = (f7 == 7'h00);
        end
      end
      7'h33: begin
        fmt = "R"; f.wb = 1;
        if (f7 == 7'h00) f.alu = f3ToAlu(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) f.alu = `ALU_OP_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) f.alu = `ALU_OP_SRA;
        else legal = 1'b0;
      end
      7'h73: begin
        fmt = "I"; f.srcB = `SEL_SRC_B_IMM;
        if (code == 32'h0000_0073) f.pcSel = `SEL_PC_MTVEC;
        else if (code == 32'h3020_0073) f.pcSel = `SEL_PC_MEPC;
      end
      default: legal = 1'b0;
    endcase
    f.rs1 = (fmt == "U" || fmt == "J") ? 5'd0 : code[19:15];
    f.rs2 = (fmt == "R" || fmt == "S" || fmt == "B") ? code[24:20] : 5'd0;
    f.rd  = (fmt == "S" || fmt == "B") ? 5'd0 : code[11:7];
    case (fmt)
      "I": v = int'($signed(code[31:20]));
      "S": v = int'($signed(code[31:25])) * 32 + int'(code[11:7]);
      "B": v = (code[31] ? -4096 : 0) + int'(code[7]) * 2048 + int'(code[30:25]) * 32 + int'(code[11:8]) * 2;
      "U": v = int'(code & 32'hFFFF_F000);
      "J": v = (code[31] ? -(1 << 20) : 0) + int'(code[19:12]) * 4096 + int'(code[20]) * 2048 + int'(code[30:21]) * 2;
      default: v = 0;
    endcase
    f.imm = 32'(v);
    if (!legal) begin
      f = '0;
      f.ill = 1'b1;
      f.pcSel = `SEL_PC_MTVEC;
    end
    f.pc = pc;
    return f;
  endfunction

  function automatic logic [31:0] randCode();
    logic [31:0] c;
    int sel;
    c = $urandom;
    sel = $urandom_range(0, 13);
    case (sel)
      0:  c[6:0] = 7'h37;
      1:  c[6:0] = 7'h17;
      2:  c[6:0] = 7'h6F;
      3:  c[6:0] = 7'h67;
      4:  c[6:0] = 7'h63;
      5:  c[6:0] = 7'h03;
      6:  c[6:0] = 7'h23;
      7:  c[6:0] = 7'h13;
      8:  c[6:0] = 7'h33;
      9:  c[6:0] = 7'h73;
      10: c = 32'h0000_0073;
      11: c = 32'h3020_0073;
      12: c = 32'h0000_0000;
      default: ;
    endcase
    if ((c[6:0] == 7'h33 || c[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      c[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return c;
  endfunction

  function automatic fields_t observed();
    return {rs1_num, rs2_num, rd_num, imm, alu_op_sel, src_a_sel, src_b_sel,
            pc_sel, wb_reg, illegal, out_pc};
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    fields_t obs;
    logic expReady;
    obs = observed();
    if (!mKnown) return;
    expReady = rst_n && !flush && (mQueue.size() != DEPTH);
    checks++;
    assert (in_ready === expReady) else begin
      errors++;
      $error("[TB] FAIL in_ready observed=%0b expected=%0b", in_ready, expReady);
    end
    checks++;
    assert (out_valid === mValid) else begin
      errors++;
      $error("[TB] FAIL out_valid observed=%0b expected=%0b", out_valid, mValid);
    end
    if (mValid) begin
      checks++;
      assert (obs === mOut) else begin
        errors++;
        $error("[TB] FAIL fields observed=%h expected=%h", obs, mOut);
      end
    end else if (mZero) begin
      checks++;
      assert (obs === '0) else begin
        errors++;
        $error("[TB] FAIL reset_fields observed=%h expected=%h", obs, fields_t'(0));
      end
    end
  endtask

  task automatic updateModel();
    logic   doPush, doLoad;
    entry_t e;
    if (!rst_n) begin
      mQueue.delete();
      mValid = 1'b0;
      mZero  = 1'b1;
      mKnown = 1'b1;
    end else if (mKnown) begin
      if (flush) begin
        mQueue.delete();
        mValid = 1'b0;
      end else begin
        doPush = in_valid && (mQueue.size() < DEPTH);
        doLoad = (mQueue.size() > 0) && (!mValid || out_ready);
        if (doLoad) begin
          e = mQueue.pop_front();
          mOut = refDecode(e.pc, e.code);
          mValid = 1'b1;
          mZero = 1'b0;
        end else if (out_ready) begin
          mValid = 1'b0;
        end
        if (doPush) begin
          e = {in_pc, in_code};
          mQueue.push_back(e);
        end
      end
    end
  endtask

  // One clock: drive, sample at the falling edge, advance the model, cross the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] code,
                               input logic ordy, input logic fl, input logic rn);
    in_valid  = v;
    in_pc     = pc;
    in_code   = code;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    @(negedge clk);
    checkOutput();
    if (in_valid && in_ready) accCount++;
    if (out_valid && out_ready) outCount++;
    updateModel();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accBefore;
    in_valid = 0; in_pc = 0; in_code = 0; out_ready = 0; flush = 0; rst_n = 0;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h40, 32'h0010_0093, 1, 1, 0);
    checkEq("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkEq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1; in_valid = 0; flush = 0; #1;
    checkEq("release_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(1, 32'h100, 32'hFFF1_0093, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkEq("addi_valid", {31'd0, out_valid}, 32'd1);
    checkEq("addi_rd", {27'd0, rd_num}, 32'd1);
    checkEq("addi_rs1", {27'd0, rs1_num}, 32'd2);
    checkEq("addi_rs2", {27'd0, rs2_num}, 32'd0);
    checkEq("addi_imm", imm, 32'hFFFF_FFFF);
    checkEq("addi_wb", {31'd0, wb_reg}, 32'd1);
    checkEq("addi_illegal", {31'd0, illegal}, 32'd0);
    checkEq("addi_pc", out_pc, 32'h100);

    applyStimulus(1, 32'h104, 32'h4020_D0B3, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkEq("sra_alu", 32'(alu_op_sel), 32'(`ALU_OP_SRA));
    checkEq("sra_srcb", 32'(src_b_sel), 32'(`SEL_SRC_B_RS2));
    checkEq("sra_rd", {27'd0, rd_num}, 32'd1);
    checkEq("sra_rs1", {27'd0, rs1_num}, 32'd1);
    checkEq("sra_rs2", {27'd0, rs2_num}, 32'd2);

    applyStimulus(1, 32'h108, 32'h0000_0000, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkEq("zero_illegal", {31'd0, illegal}, 32'd1);
    checkEq("zero_wb", {31'd0, wb_reg}, 32'd0);
    checkEq("zero_rd", {27'd0, rd_num}, 32'd0);
    checkEq("zero_pcsel", 32'(pc_sel), 32'(`SEL_PC_MTVEC));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1);

    accCount = 0; outCount = 0;
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 32'h200 + 32'(i * 4), 32'h0000_0093 | (32'(i) << 20), 0, 0, 1);
    checkEq("fill_accepted", 32'(accCount), 32'd5);
    checkEq("fill_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 1);
    checkEq("drain_per_cycle", 32'(outCount), 32'd5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1);
    checkEq("drain_total", 32'(outCount), 32'd5);

    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h300 + 32'(i * 4), 32'h0000_0113 | (32'(i) << 20), 0, 0, 1);
    accBefore = accCount;
    applyStimulus(1, 32'h400, 32'h0050_0193, 0, 1, 1);
    checkEq("flush_no_accept", 32'(accCount), 32'(accBefore));
    in_valid = 0; flush = 0; #1;
    checkEq("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("flush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1);

    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'h500 + 32'(i * 4), 32'h0000_8067 | (32'(i + 1) << 15), 0, 0, 1);
    applyStimulus(1, 32'h600, 32'h0010_0093, 1, 0, 0);
    checkEq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("rst_imm", imm, 32'd0);
    checkEq("rst_pc", out_pc, 32'd0);
    checkEq("rst_regs", {17'd0, rs1_num, rs2_num, rd_num}, 32'd0);
    checkEq("rst_sels", {20'd0, alu_op_sel, src_a_sel, src_b_sel, pc_sel, wb_reg}, 32'd0);
    rst_n = 1; in_valid = 0; #1;
    checkEq("rst_release_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 1);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, randCode(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 79) != 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 4; instruction-queue entries, power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1; occupancy counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush  input  1  discard all queued and staged instructions.
REQ-006 SHALL have port in_valid  input  1  fetch offers {in_pc, in_code}.
REQ-007 SHALL have port in_ready  output  1  queue can accept.
REQ-008 SHALL have ports in_pc, in_code  input  32 each  instruction address and word.
REQ-009 SHALL have port out_valid  output  1  decoded instruction presented.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have ports rs1_num, rs2_num, rd_num  output  5 each  register numbers.
REQ-012 SHALL have port imm  output  32  sign/zero-formed immediate.
REQ-013 SHALL have ports alu_op_sel, src_a_sel, src_b_sel, pc_sel  output  `ALU_OP_WIDTH, `SEL_SRC_A_WIDTH, `SEL_SRC_B_WIDTH, `SEL_PC_WIDTH  existing select encodings.
REQ-014 SHALL have ports wb_reg, illegal  output  1 each  register writeback; illegal encoding.
REQ-015 SHALL have port out_pc  output  32  pc of presented instruction.

Function
REQ-016 SHALL store accepted instructions in a DEPTH-entry FIFO (wrapping read/write pointers, CNT_W-bit count); push when in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH) && !flush; no same-cycle push-through when full, even if pop occurs.
REQ-018 SHALL decode the FIFO head combinationally and load results into a single output register when the head is non-empty and (!out_valid || out_ready).
REQ-019 SHALL give minimum latency 2 edges: push on edge N, out_valid high after edge N+1; sustained throughput 1 instruction/cycle.
REQ-020 SHALL hold all output fields stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on a handshake edge with no replacement available.
REQ-022 SHALL form imm per RV32I I/S/B/U/J formats; imm=0 for R-type and illegal.
REQ-023 SHALL force rs1_num=0 for U/J, rs2_num=0 for I/U/J, rd_num=0 for S/B.
REQ-024 SHALL map OP/OP-IMM funct3=101: funct7 0000000 -> `ALU_OP_SRL, 0100000 -> `ALU_OP_SRA.
REQ-025 SHALL map OP-IMM funct3=001 with funct7!=0, OP funct7 other than 0000000/0100000 (0100000 only for ADD/SUB/SRA), BRANCH funct3 010/011, and unlisted opcodes to illegal=1.
REQ-026 SHALL, for illegal=1, drive wb_reg=0, rd_num=0, alu_op_sel=`ALU_OP_NONE, pc_sel=`SEL_PC_MTVEC.
REQ-027 SHALL assign pc_sel from a complete case with no retained state: JAL, JALR, ECALL->MTVEC, MRET->MEPC, all else ADD4.
REQ-028 SHALL treat flush with priority over push, pop and output load in that cycle: next cycle count=0, pointers=0, out_valid=0.
REQ-029 SHALL keep in_ready low during the flush cycle and high on the following cycle.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, set count=0, read/write pointers=0, out_valid=0, and all output fields to 0; rst_n overrides flush and handshakes.
REQ-031 SHALL hold in_ready=0 while rst_n=0 and drive in_ready=1 on the first cycle after release.
REQ-032 SHALL discard queue contents on reset mid-operation; no post-reset out_valid until a new push.

Verification
REQ-033 SHALL check: push 0xFFF10093 at pc=0x100, out_ready=1 -> after 2 edges out_valid=1, rd_num=1, rs1_num=2, rs2_num=0, imm=0xFFFFFFFF, wb_reg=1, illegal=0, out_pc=0x100.
REQ-034 SHALL check: push 0x4020D0B3 -> alu_op_sel=`ALU_OP_SRA, src_b_sel=`SEL_SRC_B_RS2, rd_num=1, rs1_num=1, rs2_num=2.
REQ-035 SHALL check: push 0x00000000 -> illegal=1, wb_reg=0, rd_num=0, pc_sel=`SEL_PC_MTVEC.
REQ-036 SHALL check: DEPTH=4, out_ready=0, continuous in_valid -> exactly 5 accepted, in_ready=0; raise out_ready -> outputs in push order, one per cycle, no loss or duplication.
REQ-037 SHALL check: 3 queued plus 1 staged, flush with in_valid=1 -> nothing accepted that cycle, next cycle out_valid=0, in_ready=1.
REQ-038 SHALL check: rst_n=0 for 1 edge with 2 queued -> out_valid=0 and all outputs 0 after the edge; after release, in_ready=1 and no stale output appears.
